// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types, widths and saturating add for the MAC sequencer
package mac_pkg;

    localparam int OP_W   = 2;
    localparam int PROD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Returns {overflow, saturated sum}; the sum is clamped to 2^acc_w-1.
    function automatic logic [32:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] prod,
                                            input int unsigned acc_w);
        logic [32:0] raw;
        logic [32:0] max;
        raw = {1'b0, acc} + {1'b0, prod};
        max = (33'd1 << acc_w) - 33'd1;
        if (raw > max) begin
            return {1'b1, max[31:0]};
        end
        return {1'b0, raw[31:0]};
    endfunction

endpackage

// File: rtl/mac_sat_acc.sv
// rtl/mac_sat_acc.sv - saturating product accumulator with sticky overflow flag
module mac_sat_acc
    import mac_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    logic [32:0] sat_r;
    logic        sat_unused;

    assign sat_r      = sat_add(32'(acc), 32'(prod), ACC_W);
    assign sat_unused = |sat_r[31:ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= sat_r[ACC_W-1:0];
            if (sat_r[32]) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dot-product sequencer time-sharing an external 2x2-bit multiplier
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int LEN_W = 6,
    parameter int ACC_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_x,
    input  logic [OP_W-1:0]   in_w,
    output logic [OP_W-1:0]   mult_x,
    output logic [OP_W-1:0]   mult_w,
    input  logic [PROD_W-1:0] mult_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic             pv;
    logic             job_start;
    logic             accept;
    logic             last;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    assign job_start = (state == IDLE) && start;
    assign accept    = in_ready && in_valid;
    assign last      = (count == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len != '0) ? RUN : DONE;
            RUN:     if (accept && last) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            RUN: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            DRAIN: busy = 1'b1;
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand stage: the multiplier result for an accepted pair is summed the cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            count  <= '0;
            mult_x <= '0;
            mult_w <= '0;
            pv     <= 1'b0;
        end else begin
            pv <= accept;
            if (job_start) begin
                len_q <= len;
                count <= '0;
            end
            if (accept) begin
                mult_x <= in_x;
                mult_w <= in_w;
                count  <= count + LEN_W'(1);
            end
        end
    end

    mac_sat_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (job_start),
        .en    (pv),
        .prod  (mult_y),
        .acc   (acc),
        .ovf   (ovf)
    );

    assign res_data = acc;
    assign res_ovf  = ovf;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - bench for mac_seq_ctrl at default width and a 4-bit saturating width
module tb_mac_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] len;
    logic       in_valid;
    logic [1:0] in_x;
    logic [1:0] in_w;
    logic       res_ready;

    logic       busy_a, in_ready_a, res_valid_a, res_ovf_a;
    logic [1:0] mx_a, mw_a;
    logic [3:0] my_a;
    logic [9:0] res_data_a;

    logic       busy_b, in_ready_b, res_valid_b, res_ovf_b;
    logic [1:0] mx_b, mw_b;
    logic [3:0] my_b;
    logic [3:0] res_data_b;

    int n_asserts = 0;
    int n_fail    = 0;
    int px[$];
    int pw[$];

    always #5 clk = ~clk;

    assign my_a = {2'b00, mx_a} * {2'b00, mw_a};
    assign my_b = {2'b00, mx_b} * {2'b00, mw_b};

    mac_seq_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy_a),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_x      (in_x),
        .in_w      (in_w),
        .mult_x    (mx_a),
        .mult_w    (mw_a),
        .mult_y    (my_a),
        .res_valid (res_valid_a),
        .res_ready (res_ready),
        .res_data  (res_data_a),
        .res_ovf   (res_ovf_a)
    );

    mac_seq_ctrl #(.LEN_W(6), .ACC_W(4)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_x      (in_x),
        .in_w      (in_w),
        .mult_x    (mx_b),
        .mult_w    (mw_b),
        .mult_y    (my_b),
        .res_valid (res_valid_b),
        .res_ready (res_ready),
        .res_data  (res_data_b),
        .res_ovf   (res_ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  busy_a,      0);
        chk({tag, "_rdy"},   in_ready_a,  0);
        chk({tag, "_mx"},    mx_a,        0);
        chk({tag, "_mw"},    mw_a,        0);
        chk({tag, "_rv"},    res_valid_a, 0);
        chk({tag, "_data"},  res_data_a,  0);
        chk({tag, "_ovf"},   res_ovf_a,   0);
        chk({tag, "_busyb"}, busy_b,      0);
        chk({tag, "_datab"}, res_data_b,  0);
        chk({tag, "_ovfb"},  res_ovf_b,   0);
    endtask

    // Drives the job held in px/pw and checks it end to end against plain arithmetic.
    task automatic run_job(input string tag, input int bub_lo, input int bub_hi,
                           input int hold, input bit poke);
        int n;
        int sum;
        int e10, o10, e4, o4;
        int b;
        logic [1:0] keep_x, keep_w;
        n   = px.size();
        sum = 0;
        for (int i = 0; i < n; i++) sum += px[i] * pw[i];
        e10 = (sum > 1023) ? 1023 : sum;
        o10 = (sum > 1023) ? 1 : 0;
        e4  = (sum > 15) ? 15 : sum;
        o4  = (sum > 15) ? 1 : 0;
        keep_x = mx_a;
        keep_w = mw_a;

        @(negedge clk);
        start    = 1'b1;
        len      = 6'(n);
        in_valid = poke;
        in_x     = 2'($urandom);
        in_w     = 2'($urandom);
        @(negedge clk);
        start = 1'b0;
        len   = 6'($urandom);
        chk({tag, "_busy_start"}, busy_a, 1);

        if (n == 0) begin
            chk({tag, "_empty_rdy"}, in_ready_a, 0);
            chk({tag, "_empty_mx"}, {mx_a, mw_a}, {keep_x, keep_w});
        end else begin
            for (int i = 0; i < n; i++) begin
                b = (i == 0) ? 0 : int'($urandom_range(bub_hi, bub_lo));
                repeat (b) begin
                    in_valid = 1'b0;
                    in_x     = 2'($urandom);
                    start    = poke & 1'($urandom);
                    @(negedge clk);
                    chk({tag, "_bub_rdy"}, in_ready_a, 1);
                    chk({tag, "_bub_hold"}, {mx_a, mw_a}, {2'(px[i-1]), 2'(pw[i-1])});
                end
                chk({tag, "_rdy"}, in_ready_a, 1);
                in_valid = 1'b1;
                in_x     = 2'(px[i]);
                in_w     = 2'(pw[i]);
                start    = poke & 1'($urandom);
                @(negedge clk);
                start = 1'b0;
                chk({tag, "_mult"}, {mx_a, mw_a}, {2'(px[i]), 2'(pw[i])});
            end
            in_valid = poke;
            in_x     = 2'($urandom);
            chk({tag, "_drain_rdy"}, in_ready_a, 0);
            chk({tag, "_drain_rv"},  res_valid_a, 0);
            chk({tag, "_drain_busy"}, busy_a, 1);
            @(negedge clk);
        end

        for (int h = 0; h <= hold; h++) begin
            chk({tag, "_rv"},    res_valid_a, 1);
            chk({tag, "_data"},  res_data_a,  e10);
            chk({tag, "_ovf"},   res_ovf_a,   o10);
            chk({tag, "_rvb"},   res_valid_b, 1);
            chk({tag, "_datab"}, res_data_b,  e4);
            chk({tag, "_ovfb"},  res_ovf_b,   o4);
            chk({tag, "_dn_rdy"}, in_ready_a, 0);
            start     = poke;
            res_ready = (h == hold);
            @(negedge clk);
        end
        res_ready = 1'b0;
        start     = 1'b0;
        chk({tag, "_idle_busy"}, busy_a, 0);
        chk({tag, "_idle_rv"},   res_valid_a, 0);
        chk({tag, "_idle_busyb"}, busy_b, 0);

        keep_x   = mx_a;
        keep_w   = mw_a;
        in_valid = 1'b1;
        in_x     = ~keep_x;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_idle_valid"}, {busy_a, mx_a, mw_a}, {1'b0, keep_x, keep_w});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        px = '{1, 2, 3, 0};
        pw = '{1, 3, 3, 2};
        run_job("basic", 0, 0, 0, 0);

        px = '{3, 1, 2};
        pw = '{3, 2, 2};
        run_job("bubble", 2, 2, 5, 0);

        px = {};
        pw = {};
        run_job("empty", 0, 0, 1, 1);

        px = '{3, 3, 1};
        pw = '{3, 3, 1};
        run_job("sat", 0, 0, 0, 0);
        px = '{1};
        pw = '{1};
        run_job("post_sat", 0, 0, 0, 0);

        px = {};
        pw = {};
        for (int i = 0; i < 63; i++) begin
            px.push_back(3);
            pw.push_back(3);
        end
        run_job("max_len", 0, 0, 0, 0);

        // Abort a ten-pair job after five accepts.
        @(negedge clk);
        start = 1'b1;
        len   = 6'd10;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = 2'($urandom_range(3, 1));
            in_w     = 2'($urandom_range(3, 1));
            @(negedge clk);
        end
        chk("abort_busy_before", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        px = '{2};
        pw = '{2};
        run_job("after_abort", 0, 0, 0, 0);

        for (int j = 0; j < 16; j++) begin
            int n;
            n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(63, 0))
                                            : int'($urandom_range(8, 0));
            px = {};
            pw = {};
            for (int i = 0; i < n; i++) begin
                px.push_back(int'($urandom_range(3, 0)));
                pw.push_back(int'($urandom_range(3, 0)));
            end
            run_job($sformatf("rnd%0d", j), 0, 2, int'($urandom_range(3, 0)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that time-shares one 2-bit x 2-bit multiplier datapath to compute a dot product of a streamed vector of (x, w) operand pairs. It accepts a job (vector length), pulls pairs over a valid/ready stream and drives them into the multiplier. It accumulates the 4-bit products in a saturating accumulator and presents the sum on a valid/ready result port. It sits between the operand buffers and the downstream neuron/activation logic.

Parameters:
LEN_W, 6, width of the job length field; legal lengths are 0 to 2^LEN_W-1.
ACC_W, 10, accumulator and result width. At least 4. The default holds the maximum sum 63*9=567 without saturation.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
len  in  LEN_W  number of pairs in the job; sampled with start
busy  out  1  high in every state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair ready; high only in RUN
in_x  in  2  activation operand
in_w  in  2  weight operand
mult_x  out  2  registered x to multiplier
mult_w  out  2  registered w to multiplier
mult_y  in  4  combinational product from multiplier (mult_x*mult_w, unsigned)
res_valid  out  1  result valid; high only in DONE
res_ready  in  1  result consumer ready
res_data  out  ACC_W  accumulated dot product
res_ovf  out  1  sticky saturation flag for the current job

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, count=0, acc=0, ovf=0, pv (product-valid)=0, mult_x=mult_w=0.
  - All outputs low or zero.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches len.
  - Clears acc, ovf and count.
  - Next state is RUN if len!=0, else DONE (empty job: result 0, ovf=0).
- RUN:
  - in_ready=1. A pair is accepted when in_valid & in_ready.
  - On accept: mult_x<=in_x, mult_w<=in_w, pv<=1, count<=count+1. No accept: pv<=0 and mult regs hold.
  - Accepting the count==len-1 pair moves the FSM to DRAIN. in_ready is low from the next cycle.
- Accumulate stage:
  - When pv=1, acc <= sat(acc + zero-extended mult_y).
  - If the true sum exceeds 2^ACC_W-1, acc is set to 2^ACC_W-1 and ovf is set to 1 (sticky until the next start).
- DRAIN: one cycle; the last product is accumulated; next state DONE.
- Latency: last pair accepted in cycle t -> res_valid=1 in cycle t+2.
- DONE:
  - res_valid=1; res_data=acc and res_ovf=ovf, both stable.
  - Holds until res_ready=1, then IDLE.
  - res_valid and res_ready may both be high on the first DONE cycle.
- start outside IDLE is ignored, including in the DONE cycle that completes the handshake. A new job needs a start in IDLE.
- in_valid outside RUN is ignored, and no pair is consumed.
- len input changes after acceptance have no effect.
- Input bubbles (in_valid=0) in RUN stall count and accumulation, with no loss or duplication.
- rst_n asserted mid-job aborts immediately to the reset values. No partial result is emitted.

Decomposition:
- Shared package mac_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - constants OP_W=2 and PROD_W=4;
  - a function computing the saturating add.
- One natural sub-module, mac_sat_acc, contains:
  - accumulator register, ovf flag, clear and enable inputs;
  - product input of PROD_W bits; ACC_W parameter.
- The multiplier stays external; this block only drives and samples it.

Test Plan:
- Basic job: len=4, pairs (1,1),(2,3),(3,3),(0,2), in_valid held high -> in_ready for exactly 4 cycles; res_valid 2 cycles after the 4th accept; res_data=16, res_ovf=0.
- Bubbles and backpressure:
  - Stimulus: len=3, pairs (3,3),(1,2),(2,2) with in_valid low 2 cycles between pairs; res_ready held low 5 cycles.
  - Response: res_data=15 held stable with res_valid=1 until res_ready, then IDLE and busy=0.
- Empty job: start with len=0 -> DONE next cycle, res_data=0, no pair consumed while in_valid=1.
- Saturation: ACC_W=4, len=3, pairs (3,3),(3,3),(1,1) -> res_data=15, res_ovf=1. The next job with len=1 and pair (1,1) gives res_data=1, res_ovf=0.
- Reset mid-job: len=10, deassert rst_n after 5 accepts -> all outputs 0 immediately. After release, a len=1 pair (2,2) job returns 4.
- Ignored stimulus: start pulsed during RUN and DONE, in_valid in IDLE -> no state change, no pair consumed, result unchanged.
